// File: rtl/ow_protocol.sv
// Command sequencer between the Avalon FIFO interface and the 1-wire bit/byte engine.
// Optional feature macro OW_CRC8_EN: Dallas CRC8 residue byte appended after every READ.
module ow_protocol #(
    parameter int MAX_LEN      = 16,
    parameter int DONE_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic [7:0] bus_out,
    output logic       rdreq,
    input  logic       rdready,
    output logic [7:0] bus_in,
    output logic       wrreq,
    input  logic       wrready,
    output logic       ow_start,
    output logic [1:0] ow_op,
    output logic [7:0] ow_tx,
    input  logic [7:0] ow_rx,
    input  logic       ow_done,
    input  logic       ow_presence,
    input  logic       ow_error,
    output logic       cmd_ready,
    output logic       cmd_error
);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [7:0] OPC_RESET = 8'h01;
    localparam logic [7:0] OPC_WRITE = 8'h02;
    localparam logic [7:0] OPC_READ  = 8'h03;

    typedef enum logic [3:0] {
        IDLE, FETCH_OP, DECODE, FETCH_LEN, FETCH_DATA, OW_START, OW_WAIT, PUSH,
`ifdef OW_CRC8_EN
        CRC_PUSH,
`endif
        ERROR
    } state_t;

    state_t          state, state_next;
    logic [1:0]      phase, phase_next;
    logic            hs_done, ready_in, push_state, op_ok;
    logic [7:0]      op_q;
    logic [4:0]      cnt;
    logic [TW-1:0]   tcnt;

`ifdef OW_CRC8_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i])
                r = (r >> 1) ^ 8'h8C;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    assign push_state = (state == PUSH) || (state == CRC_PUSH);
`else
    assign push_state = (state == PUSH);
`endif

    // phase: 0 = request low (guarantees the inter-request gap), 1 = wait ready low, 2 = wait ready high
    assign ready_in = push_state ? wrready : rdready;
    assign rdreq    = (state == FETCH_OP) ||
                      ((state == IDLE || state == FETCH_LEN || state == FETCH_DATA) && phase != 2'd0);
    assign wrreq    = push_state && (phase != 2'd0);
    assign ow_start = (state == OW_START);
    assign op_ok    = ow_done && !ow_error;

    always_comb begin
        state_next = state;
        phase_next = phase;
        hs_done    = 1'b0;
        case (phase)
            2'd0:    phase_next = 2'd1;
            2'd1:    if (!ready_in) phase_next = 2'd2;
            default: hs_done = ready_in;
        endcase

        case (state)
            IDLE:       if (phase == 2'd1 && !rdready) state_next = FETCH_OP;
            FETCH_OP:   if (rdready) state_next = DECODE;
            DECODE: begin
                if (op_q == OPC_RESET)
                    state_next = OW_START;
                else if (op_q == OPC_WRITE || op_q == OPC_READ)
                    state_next = FETCH_LEN;
                else
                    state_next = ERROR;
            end
            FETCH_LEN: begin
                if (hs_done) begin
                    if (bus_out == 8'd0 || 32'(bus_out) > MAX_LEN)
                        state_next = ERROR;
                    else if (op_q == OPC_WRITE)
                        state_next = FETCH_DATA;
                    else
                        state_next = OW_START;
                end
            end
            FETCH_DATA: if (hs_done) state_next = OW_START;
            OW_START:   state_next = OW_WAIT;
            OW_WAIT: begin
                if (ow_done) begin
                    if (ow_error)
                        state_next = ERROR;
                    else if (op_q == OPC_WRITE)
                        state_next = (cnt == 5'd1) ? IDLE : FETCH_DATA;
                    else
                        state_next = PUSH;
                end else if (tcnt == TW'(DONE_TIMEOUT)) begin
                    state_next = ERROR;
                end
            end
            PUSH: begin
                if (hs_done) begin
                    if (op_q == OPC_READ && cnt != 5'd0)
                        state_next = OW_START;
`ifdef OW_CRC8_EN
                    else if (op_q == OPC_READ)
                        state_next = CRC_PUSH;
`endif
                    else
                        state_next = IDLE;
                end
            end
`ifdef OW_CRC8_EN
            CRC_PUSH:   if (hs_done) state_next = IDLE;
`endif
            ERROR:      state_next = ERROR;
            default:    state_next = IDLE;
        endcase

        if (state_next != state)
            phase_next = 2'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            phase     <= 2'd0;
            cmd_ready <= 1'b0;
            cmd_error <= 1'b0;
            ow_op     <= 2'd0;
            ow_tx     <= 8'd0;
            bus_in    <= 8'd0;
        end else if (clear) begin
            state     <= IDLE;
            phase     <= 2'd0;
            cmd_ready <= 1'b0;
            cmd_error <= 1'b0;
            ow_op     <= 2'd0;
            ow_tx     <= 8'd0;
            bus_in    <= 8'd0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            cmd_ready <= (state_next == IDLE);
            if (state_next == ERROR)
                cmd_error <= 1'b1;
            // opcodes 01/02/03 map onto engine ops 00/01/10
            if (state_next == OW_START)
                ow_op <= op_q[1:0] - 2'd1;
            if (state == FETCH_DATA && hs_done)
                ow_tx <= bus_out;
            if (state == OW_WAIT && op_ok && op_q != OPC_WRITE)
                bus_in <= (op_q == OPC_RESET) ? {7'b0, ow_presence} : ow_rx;
`ifdef OW_CRC8_EN
            if (state == PUSH && state_next == CRC_PUSH)
                bus_in <= crc;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (state == FETCH_OP && rdready)
            op_q <= bus_out;
        if (state == FETCH_LEN && hs_done)
            cnt <= bus_out[4:0];
        else if (state == OW_WAIT && op_ok)
            cnt <= cnt - 5'd1;
        if (state == OW_START)
            tcnt <= '0;
        else if (state == OW_WAIT)
            tcnt <= tcnt + TW'(1);
`ifdef OW_CRC8_EN
        if (state == FETCH_LEN && hs_done)
            crc <= 8'h00;
        else if (state == OW_WAIT && op_ok && op_q == OPC_READ)
            crc <= crc8_byte(crc, ow_rx);
`endif
    end

endmodule

// File: tb/tb_ow_protocol.sv
// Scoreboard bench for ow_protocol: FIFO and engine responders, queued expectations, monitors.
module tb_ow_protocol;
    logic       clk = 1'b0;
    logic       reset_n, clear;
    logic [7:0] bus_out;
    logic       rdreq, rdready;
    logic [7:0] bus_in;
    logic       wrreq, wrready;
    logic       ow_start;
    logic [1:0] ow_op;
    logic [7:0] ow_tx, ow_rx;
    logic       ow_done, ow_presence, ow_error;
    logic       cmd_ready, cmd_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] out_q[$];
    logic [7:0] rx_q[$];
    logic [9:0] exp_start[$];
    logic [7:0] exp_push[$];

    logic eng_hold = 1'b0;
    logic eng_err = 1'b0;
    logic eng_pres = 1'b0;
    logic eng_pending = 1'b0;

    always #5 clk = ~clk;

    ow_protocol #(.MAX_LEN(16), .DONE_TIMEOUT(40)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .bus_out(bus_out), .rdreq(rdreq), .rdready(rdready),
        .bus_in(bus_in), .wrreq(wrreq), .wrready(wrready),
        .ow_start(ow_start), .ow_op(ow_op), .ow_tx(ow_tx),
        .ow_rx(ow_rx), .ow_done(ow_done), .ow_presence(ow_presence), .ow_error(ow_error),
        .cmd_ready(cmd_ready), .cmd_error(cmd_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // outbound FIFO: serves queued bytes, stalls while empty
    initial begin
        rdready = 1'b1;
        bus_out = 8'h00;
        forever begin
            @(negedge clk);
            if (rdreq && out_q.size() > 0) begin
                rdready = 1'b0;
                @(negedge clk);
                bus_out = out_q.pop_front();
                rdready = 1'b1;
                @(negedge clk);
                while (rdreq) @(negedge clk);
            end
        end
    end

    // inbound FIFO + push monitor
    initial begin
        logic [7:0] got;
        wrready = 1'b1;
        forever begin
            @(negedge clk);
            if (wrreq) begin
                got = bus_in;
                wrready = 1'b0;
                @(negedge clk);
                chk("bus_in_stable", 32'(bus_in), 32'(got));
                if (exp_push.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL push_unexpected: actual %0h required no push", got);
                end else begin
                    chk("push_data", 32'(got), 32'(exp_push.pop_front()));
                end
                wrready = 1'b1;
                @(negedge clk);
                while (wrreq) @(negedge clk);
            end
        end
    end

    // engine start monitor
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (ow_start) begin
                if (exp_start.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL start_unexpected: actual op %0h required no start", ow_op);
                end else begin
                    e = exp_start.pop_front();
                    chk("ow_op", 32'(ow_op), 32'(e[9:8]));
                    if (e[9:8] == 2'b01)
                        chk("ow_tx", 32'(ow_tx), 32'(e[7:0]));
                end
            end
        end
    end

    // 1-wire engine model
    initial begin
        int eng_delay;
        logic [1:0] eng_op;
        eng_delay = 0;
        eng_op = 2'b00;
        ow_done = 1'b0;
        ow_rx = 8'h00;
        ow_presence = 1'b0;
        ow_error = 1'b0;
        forever begin
            @(negedge clk);
            ow_done = 1'b0;
            if (ow_start) begin
                eng_pending = 1'b1;
                eng_delay = 3;
                eng_op = ow_op;
            end else if (eng_pending && !eng_hold) begin
                if (eng_delay > 0) begin
                    eng_delay--;
                end else begin
                    ow_done = 1'b1;
                    ow_error = eng_err;
                    ow_presence = eng_pres;
                    ow_rx = (eng_op == 2'b10 && rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
                    eng_pending = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((out_q.size() != 0 || exp_start.size() != 0 || exp_push.size() != 0 ||
                eng_pending || wrreq) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
        chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({name, "_cmd_error"}, 32'(cmd_error), 32'd0);
    endtask

    task automatic wait_error(input string name, input int budget);
        int n;
        logic seen;
        n = 0;
        while (!cmd_error && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_cmd_error"}, 32'(cmd_error), 32'd1);
        chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdreq || wrreq) seen = 1'b1;
        end
        chk({name, "_req_quiet"}, 32'(seen), 32'd0);
    endtask

    task automatic do_clear(input string name);
        @(negedge clk);
        clear = 1'b1;
        out_q.delete();
        @(negedge clk);
        clear = 1'b0;
        chk({name, "_clr_error"}, 32'(cmd_error), 32'd0);
        @(negedge clk);
        chk({name, "_clr_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic wait_starts(input string name);
        int n;
        n = 0;
        while (exp_start.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_start_seen"}, 32'(n < 200), 32'd1);
    endtask

    initial begin
        logic [7:0] rom [8];
        logic seen;
        rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
        reset_n = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdreq", 32'(rdreq), 32'd0);
        chk("rst_wrreq", 32'(wrreq), 32'd0);
        chk("rst_ow_start", 32'(ow_start), 32'd0);
        chk("rst_cmd_error", 32'(cmd_error), 32'd0);
        chk("rst_ow_op", 32'(ow_op), 32'd0);
        chk("rst_ow_tx", 32'(ow_tx), 32'd0);
        chk("rst_bus_in", 32'(bus_in), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_rdreq", 32'(rdreq), 32'd1);

        // RESET command, presence 1 then 0
        eng_pres = 1'b1;
        exp_start.push_back({2'b00, 8'h00});
        exp_push.push_back(8'h01);
        out_q.push_back(8'h01);
        wait_idle("reset_p1");
        eng_pres = 1'b0;
        exp_start.push_back({2'b00, 8'h00});
        exp_push.push_back(8'h00);
        out_q.push_back(8'h01);
        wait_idle("reset_p0");

        // WRITE 2 bytes
        exp_start.push_back({2'b01, 8'hCC});
        exp_start.push_back({2'b01, 8'h44});
        out_q.push_back(8'h02); out_q.push_back(8'h02);
        out_q.push_back(8'hCC); out_q.push_back(8'h44);
        wait_idle("write2");

        // READ 8 bytes of a ROM code whose last byte is its CRC
        for (int i = 0; i < 8; i++) begin
            rx_q.push_back(rom[i]);
            exp_start.push_back({2'b10, 8'h00});
            exp_push.push_back(rom[i]);
        end
`ifdef OW_CRC8_EN
        exp_push.push_back(8'h00);
`endif
        out_q.push_back(8'h03); out_q.push_back(8'h08);
        wait_idle("read8");

        // WRITE at the MAX_LEN boundary
        out_q.push_back(8'h02); out_q.push_back(8'd16);
        for (int i = 0; i < 16; i++) begin
            exp_start.push_back({2'b01, 8'(i * 17 + 3)});
            out_q.push_back(8'(i * 17 + 3));
        end
        wait_idle("write16");

        // READ single byte
        rx_q.push_back(8'h01);
        exp_start.push_back({2'b10, 8'h00});
        exp_push.push_back(8'h01);
`ifdef OW_CRC8_EN
        exp_push.push_back(8'h5E);
`endif
        out_q.push_back(8'h03); out_q.push_back(8'h01);
        wait_idle("read1");

        // illegal opcode
        out_q.push_back(8'h07);
        wait_error("bad_opcode", 100);
        do_clear("bad_opcode");

        // length out of range
        out_q.push_back(8'h02); out_q.push_back(8'h00);
        wait_error("len_zero", 100);
        do_clear("len_zero");
        out_q.push_back(8'h03); out_q.push_back(8'h11);
        wait_error("len_17", 100);
        do_clear("len_17");

        // engine never completes -> timeout
        eng_hold = 1'b1;
        exp_start.push_back({2'b01, 8'h5A});
        out_q.push_back(8'h02); out_q.push_back(8'h01); out_q.push_back(8'h5A);
        wait_starts("timeout");
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cmd_error) seen = 1'b1;
        end
        chk("timeout_early", 32'(seen), 32'd0);
        wait_error("timeout", 40);
        do_clear("timeout");
        eng_hold = 1'b0;
        repeat (10) @(negedge clk);
        chk("late_done_ignored_err", 32'(cmd_error), 32'd0);
        chk("late_done_ignored_rdy", 32'(cmd_ready), 32'd1);

        // engine fault
        eng_err = 1'b1;
        exp_start.push_back({2'b01, 8'h77});
        out_q.push_back(8'h02); out_q.push_back(8'h01); out_q.push_back(8'h77);
        wait_error("ow_error", 100);
        eng_err = 1'b0;
        do_clear("ow_error");

        // clear while waiting on the engine: result discarded, next command works
        eng_hold = 1'b1;
        exp_start.push_back({2'b00, 8'h00});
        out_q.push_back(8'h01);
        wait_starts("mid_clear");
        repeat (5) @(negedge clk);
        do_clear("mid_clear");
        eng_hold = 1'b0;
        repeat (10) @(negedge clk);
        eng_pres = 1'b1;
        exp_start.push_back({2'b00, 8'h00});
        exp_push.push_back(8'h01);
        out_q.push_back(8'h01);
        wait_idle("after_clear");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "global timeout");
    end
endmodule
